load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane.sv | 49 ++++
 rtl/load_store_unit.sv | 97 +++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule that decides whether a request can touch memory.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // True when the request must be rejected without a memory access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane logic: extracts a byte/halfword from a memory word for loads
// and merges store data into the addressed lane for read-modify-write.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] word,
  input  logic [SIZE-1:0] wdata,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [SIZE-1:0] load_data,
  output logic [SIZE-1:0] merged
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte offset 0 is the most significant lane of the word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign lanes[gi] = word[SIZE-1-8*gi -: 8];
      assign hit = (size == SZ_BYTE && offset == LANE) ||
                   (size == SZ_HALF && offset[1] == LANE[1]);
      assign merged[SIZE-1-8*gi -: 8] =
          (size == SZ_WORD)            ? wdata[SIZE-1-8*gi -: 8] :
          (hit && size == SZ_HALF && !LANE[0]) ? wdata[15:8] :
          hit                          ? wdata[7:0] :
                                         lanes[gi];
    end
  endgenerate

  assign byte_sel = lanes[offset];
  assign half_sel = offset[1] ? {lanes[2], lanes[3]} : {lanes[0], lanes[1]};

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{(SIZE-8){~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{(SIZE-16){~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding CPU request, sub-word stores done as
// read-modify-write against a combinational-read word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [SIZE-1:0] resp_rdata,
  output logic            resp_err,
  output logic            memRead,
  output logic            memWrite,
  output logic [SIZE-1:0] address,
  output logic [SIZE-1:0] WriteData,
  input  logic [SIZE-1:0] ReadData
);

  logic [1:0]      state_reg, state_next;
  logic            write_reg, unsigned_reg, err_reg;
  logic [1:0]      size_reg;
  logic [SIZE-1:0] addr_reg, wdata_reg, rdata_reg;
  logic [SIZE-1:0] load_data, merged;
  logic            accept;

  assign accept = (state_reg == ST_IDLE) && req_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0]))  state_next = ST_RESP;
          else if (req_write && req_size == SZ_WORD)   state_next = ST_WRITE;
          else                                         state_next = ST_READ;
        end
      end
      ST_READ:  state_next = write_reg ? ST_WRITE : ST_RESP;
      ST_WRITE: state_next = ST_RESP;
      default:  state_next = resp_ready ? ST_IDLE : ST_RESP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      write_reg    <= 1'b0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        write_reg    <= req_write;
        size_reg     <= req_size;
        unsigned_reg <= req_unsigned;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        err_reg      <= is_misaligned(req_size, req_addr[1:0]);
      end
      if (state_reg == ST_READ) rdata_reg <= ReadData;
    end
  end

  lsu_lane #(.SIZE(SIZE)) u_lane (
    .word        (rdata_reg),
    .wdata       (wdata_reg),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign req_ready  = (state_reg == ST_IDLE);
  assign memRead    = (state_reg == ST_READ);
  assign memWrite   = (state_reg == ST_WRITE);
  assign address    = {addr_reg[SIZE-1:2], 2'b00};
  assign WriteData  = (state_reg == ST_WRITE) ? merged : '0;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_err   = (state_reg == ST_RESP) && err_reg;
  // Response data is derived from registers only, so it stays put while stalled.
  assign resp_rdata = (state_reg == ST_RESP && !write_reg && !err_reg) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a big-endian word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        memRead, memWrite;
  logic [31:0] address, WriteData, ReadData;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int rd_count = 0;
  int both_count = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic        mem_init = 1'b1;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  load_store_unit #(.SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .WriteData(WriteData), .ReadData(ReadData)
  );

  assign ReadData = mem[address[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'd9;
      mem[2]  <= 32'h11223344;
      mem[10] <= 32'd57;
      mem[12] <= 32'd0;
    end else if (memWrite) begin
      mem[address[5:2]] <= WriteData;
    end
    if (memWrite) begin
      wr_count++;
      last_waddr <= address;
      last_wdata <= WriteData;
    end
    if (memRead) rd_count++;
    if (memRead && memWrite) both_count++;
  end

  // Issues one request from IDLE and waits (bounded) for the first resp_valid.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (memRead !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL reset_mem_ctrl got rd=%b wr=%b want 0/0", memRead, memWrite); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got v=%b e=%b want 0/0", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
  endtask

  task automatic test_loads;
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'h0, lat, rd, er);
    $display("LW 40: lat=%0d rdata=%h err=%b", lat, rd, er);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw40_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h00000039 || er !== 1'b0) begin errors++; $display("FAIL lw40_data got %h/%b want 00000039/0", rd, er); end
    do_req(1'b0, 2'b00, 1'b1, 32'd3, 32'h0, lat, rd, er);
    $display("LBU 3: lat=%0d rdata=%h err=%b", lat, rd, er);
    checks++; if (rd !== 32'h00000009 || lat !== 2) begin errors++; $display("FAIL lbu3 got %h lat %0d want 00000009 lat 2", rd, lat); end
    do_req(1'b0, 2'b00, 1'b0, 32'd0, 32'h0, lat, rd, er);
    $display("LB 0: lat=%0d rdata=%h err=%b", lat, rd, er);
    checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL lb0 got %h want 00000000", rd); end
  endtask

  task automatic test_store_byte;
    int lat, w0; logic [31:0] rd; logic er;
    w0 = wr_count;
    do_req(1'b1, 2'b00, 1'b0, 32'd1, 32'h000000AB, lat, rd, er);
    $display("SB AB@1: lat=%0d waddr=%h wdata=%h", lat, last_waddr, last_wdata);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb1_latency got %0d want 3", lat); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL sb1_write_count got %0d want 1", wr_count - w0); end
    checks++; if (last_waddr !== 32'h0 || last_wdata !== 32'h00AB0009) begin errors++; $display("FAIL sb1_write got %h@%h want 00AB0009@0", last_wdata, last_waddr); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sb1_resp got %h/%b want 0/0", rd, er); end
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rd, er);
    $display("LW 0: rdata=%h", rd);
    checks++; if (rd !== 32'h00AB0009) begin errors++; $display("FAIL lw0_after_sb got %h want 00AB0009", rd); end
  endtask

  task automatic test_sign_ext;
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'd48, 32'h00000080, lat, rd, er);
    $display("SB 80@48: wdata=%h", last_wdata);
    checks++; if (last_wdata !== 32'h80000000) begin errors++; $display("FAIL sb48_write got %h want 80000000", last_wdata); end
    do_req(1'b0, 2'b00, 1'b0, 32'd48, 32'h0, lat, rd, er);
    $display("LB 48: rdata=%h", rd);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb48 got %h want FFFFFF80", rd); end
    do_req(1'b0, 2'b00, 1'b1, 32'd48, 32'h0, lat, rd, er);
    $display("LBU 48: rdata=%h", rd);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu48 got %h want 00000080", rd); end
  endtask

  task automatic test_halfword_and_word_store;
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 2'b01, 1'b1, 32'd0, 32'h0, lat, rd, er);
    $display("LHU 0: rdata=%h", rd);
    checks++; if (rd !== 32'h000000AB) begin errors++; $display("FAIL lhu0 got %h want 000000AB", rd); end
    do_req(1'b0, 2'b01, 1'b0, 32'd2, 32'h0, lat, rd, er);
    $display("LH 2: rdata=%h", rd);
    checks++; if (rd !== 32'h00000009) begin errors++; $display("FAIL lh2 got %h want 00000009", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'd50, 32'h1234BEEF, lat, rd, er);
    $display("SH BEEF@50: lat=%0d wdata=%h", lat, last_wdata);
    checks++; if (last_wdata !== 32'h8000BEEF || lat !== 3) begin errors++; $display("FAIL sh50 got %h lat %0d want 8000BEEF lat 3", last_wdata, lat); end
    do_req(1'b0, 2'b01, 1'b0, 32'd50, 32'h0, lat, rd, er);
    $display("LH 50: rdata=%h", rd);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh50 got %h want FFFFBEEF", rd); end
    do_req(1'b1, 2'b10, 1'b0, 32'd44, 32'h12345678, lat, rd, er);
    $display("SW 44: lat=%0d waddr=%h wdata=%h", lat, last_waddr, last_wdata);
    checks++; if (lat !== 2 || last_waddr !== 32'd44 || last_wdata !== 32'h12345678) begin errors++; $display("FAIL sw44 got lat %0d %h@%h want lat 2 12345678@2c", lat, last_wdata, last_waddr); end
    do_req(1'b0, 2'b00, 1'b1, 32'd45, 32'h0, lat, rd, er);
    $display("LBU 45: rdata=%h", rd);
    checks++; if (rd !== 32'h00000034) begin errors++; $display("FAIL lbu45 got %h want 00000034", rd); end
  endtask

  task automatic test_misaligned;
    int lat, r0, w0; logic [31:0] rd; logic er;
    r0 = rd_count; w0 = wr_count;
    do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'h0, lat, rd, er);
    $display("LH 1: lat=%0d rdata=%h err=%b", lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lh1_err got lat %0d err %b rd %h want 1/1/0", lat, er, rd); end
    do_req(1'b0, 2'b10, 1'b0, 32'd2, 32'h0, lat, rd, er);
    $display("LW 2: lat=%0d rdata=%h err=%b", lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL lw2_err got lat %0d err %b want 1/1", lat, er); end
    do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'hFFFFFFFF, lat, rd, er);
    $display("size 11 store: lat=%0d err=%b", lat, er);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL size11_err got lat %0d err %b want 1/1", lat, er); end
    @(negedge clk);
    checks++; if (rd_count !== r0 || wr_count !== w0) begin errors++; $display("FAIL err_no_access got rd %0d wr %0d accesses want 0/0", rd_count - r0, wr_count - w0); end
  endtask

  task automatic test_reset_mid;
    int w0;
    w0 = wr_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'd8; req_wdata = 32'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL midrst_in_read got memRead %b want 1", memRead); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset in READ: req_ready=%b memWrite=%b resp_valid=%b", req_ready, memWrite, resp_valid);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got ready %b valid %b want 1/0", req_ready, resp_valid); end
    repeat (4) @(negedge clk);
    checks++; if (wr_count !== w0 || resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_write got %0d writes valid %b want 0/0", wr_count - w0, resp_valid); end
    checks++; if (mem[2] !== 32'h11223344) begin errors++; $display("FAIL midrst_mem got %h want 11223344", mem[2]); end
  endtask

  task automatic test_resp_hold;
    int lat; logic [31:0] rd; logic er;
    resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'd40, 32'h0, lat, rd, er);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      $display("hold cycle %0d: valid=%b rdata=%h", i, resp_valid, resp_rdata);
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00000039 || resp_err !== 1'b0) begin errors++; $display("FAIL resp_hold%0d got %b/%h want 1/00000039", i, resp_valid, resp_rdata); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL resp_release got valid %b ready %b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_ignore_busy;
    int r0;
    r0 = rd_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rd_count - r0 !== 1 || req_ready !== 1'b1) begin errors++; $display("FAIL busy_ignored got %0d reads ready %b want 1/1", rd_count - r0, req_ready); end
    checks++; if (both_count !== 0) begin errors++; $display("FAIL rd_wr_overlap got %0d cycles want 0", both_count); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_byte();
    test_sign_ext();
    test_halfword_and_word_store();
    test_misaligned();
    test_reset_mid();
    test_resp_hold();
    test_ignore_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
